// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 integer datapath: walks fetch/decode/exec/mem/wb,
// runs the imem/dmem req/ack handshakes and emits per-phase register-file controls.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start_i (with halt_i low)
// FETCH  | imem_req_o high until imem_ack_i; IR load on the ack cycle
// DECODE | classify latched opcode/funct3, illegal goes to TRAP
// EXEC   | ALU cycle; loads/stores continue to MEM, R/I to WB
// MEM    | dmem_req_o high until dmem_ack_i; stores retire here
// WB     | register write (unless rd==0) and PC+4
// TRAP   | sticky until reset; everything quiet except trap_o

module multicycle_ctrl #(
    parameter int ACK_TIMEOUT = 15,
    parameter int TMO_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        halt_i,
    input  logic [31:0] instr_i,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    output logic        ir_en_o,
    output logic        pc_en_o,
    output logic        RegWEn,
    output logic        ALUSrc,
    output logic [2:0]  selStore,
    output logic        wb_sel_o,
    output logic        busy_o,
    output logic        trap_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [4:0]       rd_q, rd_d;
    logic [TMO_W-1:0] wait_q, wait_d;

    logic is_load_q, is_store_q, legal_q;
    logic is_r_d, is_load_d, is_store_d;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[31:15];

    assign is_load_q  = (opcode_q == OP_LOAD);
    assign is_store_q = (opcode_q == OP_STORE);
    assign is_r_d     = (opcode_d == OP_R);
    assign is_load_d  = (opcode_d == OP_LOAD);
    assign is_store_d = (opcode_d == OP_STORE);

    always_comb begin
        legal_q = 1'b0;
        case (opcode_q)
            OP_R, OP_I: legal_q = 1'b1;
            OP_LOAD:    legal_q = (funct3_q inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            OP_STORE:   legal_q = (funct3_q <= 3'd2);
            default:    legal_q = 1'b0;
        endcase
    end

    // Ack strobes are combinational so the datapath can load IR / PC in the ack cycle.
    assign ir_en_o = (state_q == S_FETCH) && imem_ack_i;
    assign pc_en_o = (state_q == S_WB) ||
                     ((state_q == S_MEM) && is_store_q && dmem_ack_i);

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        wait_d   = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !halt_i) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    opcode_d = instr_i[6:0];
                    funct3_d = instr_i[14:12];
                    rd_d     = instr_i[11:7];
                    state_d  = S_DECODE;
                end else if (wait_q == TMO_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: state_d = legal_q ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_load_q || is_store_q) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack_i) begin
                    if (is_store_q) begin
                        state_d = halt_i ? S_IDLE : S_FETCH;
                        wait_d  = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == TMO_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                state_d = halt_i ? S_IDLE : S_FETCH;
                wait_d  = '0;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Phase outputs are registered from the next-state view so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            opcode_q   <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            wait_q     <= '0;
            imem_req_o <= 1'b0;
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            RegWEn     <= 1'b0;
            ALUSrc     <= 1'b0;
            selStore   <= 3'b000;
            wb_sel_o   <= 1'b0;
            busy_o     <= 1'b0;
            trap_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            wait_q     <= wait_d;
            imem_req_o <= (state_d == S_FETCH);
            dmem_req_o <= (state_d == S_MEM);
            dmem_we_o  <= (state_d == S_MEM) && is_store_d;
            RegWEn     <= (state_d == S_WB) && (rd_d != 5'd0);
            ALUSrc     <= ((state_d == S_EXEC) && !is_r_d) || (state_d == S_MEM);
            selStore   <= (((state_d == S_EXEC) || (state_d == S_MEM)) && is_store_d)
                          ? funct3_d : 3'b000;
            wb_sel_o   <= ((state_d == S_MEM) || (state_d == S_WB)) && is_load_d;
            busy_o     <= (state_d != S_IDLE) && (state_d != S_TRAP);
            trap_o     <= (state_d == S_TRAP);
        end
    end

endmodule
